bcd_updown_counter: RTL and testbench

- Parametrised multi-digit synchronous BCD counter built from cascaded decade cells.
- Supports up/down counting, parallel load, synchronous clear, and wrap or saturate mode.
- Provides a combinational terminal-count output so several instances can be chained.
- Used as the counting core for timers and display drivers. It replaces single-digit ripple-clear decade counters with a fully synchronous design.

---
 rtl/bcd_pkg.sv | 21 ++
 rtl/bcd_digit.sv | 51 +++++
 rtl/bcd_updown_counter.sv | 72 +++++++
 tb/tb_bcd_updown_counter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared constants, digit operation encoding and BCD helpers
package bcd_pkg;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_MIN = 4'd0;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  typedef enum logic [1:0] {
    OP_HOLD  = 2'd0,
    OP_CLEAR = 2'd1,
    OP_LOAD  = 2'd2,
    OP_COUNT = 2'd3
  } digit_op_e;

  function automatic logic is_bcd(input logic [3:0] nibble);
    return nibble <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - one decade cell with clear, guarded load and up/down step
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic       sync_clr,
  input  logic       load,
  input  logic       load_ok,
  input  logic [3:0] d,
  input  logic       step,
  input  logic       up_dn,
  output logic [3:0] q,
  output logic       at_max,
  output logic       at_min
);

  digit_op_e  op;
  logic [3:0] inc_val;
  logic [3:0] dec_val;

  always_comb begin
    op = OP_HOLD;
    if (sync_clr)            op = OP_CLEAR;
    else if (load)           op = (load_ok) ? OP_LOAD : OP_HOLD;
    else if (step)           op = OP_COUNT;
  end

  // Out-of-range nibbles recover to 0 going up and to 9 going down.
  always_comb begin
    inc_val = (q >= BCD_MAX) ? BCD_MIN : q + 4'd1;
    dec_val = (q == BCD_MIN || !is_bcd(q)) ? BCD_MAX : q - 4'd1;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      q <= BCD_MIN;
    end else begin
      case (op)
        OP_CLEAR: q <= BCD_MIN;
        OP_LOAD:  q <= d;
        OP_COUNT: q <= (up_dn == DIR_UP) ? inc_val : dec_val;
        default:  q <= q;
      endcase
    end
  end

  assign at_max = (q == BCD_MAX);
  assign at_min = (q == BCD_MIN);

endmodule

// File: rtl/bcd_updown_counter.sv
// rtl/bcd_updown_counter.sv - multi-digit synchronous BCD up/down counter with cascade tc
module bcd_updown_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter bit WRAP   = 1'b1
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  sync_clr,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  en,
  input  logic                  up_dn,
  output logic [4*DIGITS-1:0]   q,
  output logic                  tc,
  output logic                  load_err
);

  logic [DIGITS-1:0] at_max;
  logic [DIGITS-1:0] at_min;
  logic [DIGITS-1:0] step;
  logic              load_ok;
  logic              at_term;
  logic              count_en;

  // A load is all-or-nothing: one bad nibble rejects the whole value.
  always_comb begin
    load_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (!is_bcd(load_val[4*i +: 4])) load_ok = 1'b0;
    end
  end

  assign at_term  = (up_dn == DIR_DN) ? (&at_min) : (&at_max);
  assign count_en = en && (WRAP || !at_term);
  assign tc       = en && !sync_clr && !load && at_term;

  // Digit k steps only when every lower digit is at its rollover value.
  always_comb begin
    step    = '0;
    step[0] = count_en;
    for (int k = 1; k < DIGITS; k++) begin
      step[k] = step[k-1] && ((up_dn == DIR_UP) ? at_max[k-1] : at_min[k-1]);
    end
  end

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    bcd_digit u_digit (
      .clk      (clk),
      .clr      (clr),
      .sync_clr (sync_clr),
      .load     (load),
      .load_ok  (load_ok),
      .d        (load_val[4*k +: 4]),
      .step     (step[k]),
      .up_dn    (up_dn),
      .q        (q[4*k +: 4]),
      .at_max   (at_max[k]),
      .at_min   (at_min[k])
    );
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      load_err <= 1'b0;
    end else begin
      load_err <= !sync_clr && load && !load_ok;
    end
  end

endmodule

// File: tb/tb_bcd_updown_counter.sv
// tb/tb_bcd_updown_counter.sv - vector table and scoreboard bench for bcd_updown_counter
module tb_bcd_updown_counter;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       sync_clr = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_val = 8'h00;
  logic       en = 1'b0;
  logic       up_dn = 1'b1;

  logic [7:0] q_w, q_s;
  logic       tc_w, tc_s, err_w, err_s;

  logic       cen = 1'b0;
  logic [3:0] lo_q, hi_q;
  logic       lo_tc, hi_tc, lo_err, hi_err;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  bcd_updown_counter #(.DIGITS(2), .WRAP(1'b1)) dut_wrap (
    .clk(clk), .clr(clr), .sync_clr(sync_clr), .load(load), .load_val(load_val),
    .en(en), .up_dn(up_dn), .q(q_w), .tc(tc_w), .load_err(err_w)
  );

  bcd_updown_counter #(.DIGITS(2), .WRAP(1'b0)) dut_sat (
    .clk(clk), .clr(clr), .sync_clr(sync_clr), .load(load), .load_val(load_val),
    .en(en), .up_dn(up_dn), .q(q_s), .tc(tc_s), .load_err(err_s)
  );

  bcd_updown_counter #(.DIGITS(1), .WRAP(1'b1)) c_lo (
    .clk(clk), .clr(clr), .sync_clr(1'b0), .load(1'b0), .load_val(4'h0),
    .en(cen), .up_dn(1'b1), .q(lo_q), .tc(lo_tc), .load_err(lo_err)
  );

  bcd_updown_counter #(.DIGITS(1), .WRAP(1'b1)) c_hi (
    .clk(clk), .clr(clr), .sync_clr(1'b0), .load(1'b0), .load_val(4'h0),
    .en(lo_tc), .up_dn(1'b1), .q(hi_q), .tc(hi_tc), .load_err(hi_err)
  );

  typedef struct {
    logic       sc;
    logic       ld;
    logic [7:0] lv;
    logic       en;
    logic       ud;
    logic       tcw;
    logic       tcs;
    logic [7:0] qw;
    logic [7:0] qs;
    logic       err;
  } vec_t;

  typedef struct {
    logic [7:0] qw;
    logic [7:0] qs;
    logic       err;
  } exp_t;

  vec_t vq_a[$];
  vec_t vq_b[$];
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic sc, input logic ld, input logic [7:0] lv,
                              input logic e, input logic ud, input logic tcw, input logic tcs,
                              input logic [7:0] qw, input logic [7:0] qs, input logic err);
    vec_t v;
    v.sc = sc; v.ld = ld; v.lv = lv; v.en = e; v.ud = ud;
    v.tcw = tcw; v.tcs = tcs; v.qw = qw; v.qs = qs; v.err = err;
    return v;
  endfunction

  function automatic logic [7:0] to_bcd(input int k);
    logic [3:0] hi, lo;
    hi = 4'(k / 10);
    lo = 4'(k % 10);
    return {hi, lo};
  endfunction

  task automatic drive_vec(input vec_t v, input string tag);
    exp_t e;
    @(negedge clk);
    sync_clr = v.sc; load = v.ld; load_val = v.lv; en = v.en; up_dn = v.ud;
    #1;
    check({tag, " tc_wrap"}, 32'(tc_w), 32'(v.tcw));
    check({tag, " tc_sat"},  32'(tc_s), 32'(v.tcs));
    e.qw = v.qw; e.qs = v.qs; e.err = v.err;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, " scoreboard_empty"}, 32'(0), 32'(1));
    end else begin
      e = sb.pop_front();
      check({tag, " q_wrap"},   32'(q_w),   32'(e.qw));
      check({tag, " q_sat"},    32'(q_s),   32'(e.qs));
      check({tag, " err_wrap"}, 32'(err_w), 32'(e.err));
      check({tag, " err_sat"},  32'(err_s), 32'(e.err));
    end
  endtask

  initial begin
    //               sc  ld  lv     en  ud  tcw tcs qw     qs     err
    vq_a.push_back(mk(0, 1, 8'h35, 0, 1, 0, 0, 8'h35, 8'h35, 0));
    vq_a.push_back(mk(0, 0, 8'h00, 1, 1, 0, 0, 8'h36, 8'h36, 0));
    vq_a.push_back(mk(0, 0, 8'h00, 1, 1, 0, 0, 8'h37, 8'h37, 0));

    vq_b.push_back(mk(0, 1, 8'h98, 1, 1, 0, 0, 8'h98, 8'h98, 0));
    vq_b.push_back(mk(0, 0, 8'h00, 1, 1, 0, 0, 8'h99, 8'h99, 0));
    vq_b.push_back(mk(0, 0, 8'h00, 1, 1, 1, 1, 8'h00, 8'h99, 0));
    vq_b.push_back(mk(0, 0, 8'h00, 1, 1, 0, 1, 8'h01, 8'h99, 0));
    vq_b.push_back(mk(0, 1, 8'h10, 0, 1, 0, 0, 8'h10, 8'h10, 0));
    vq_b.push_back(mk(0, 0, 8'h00, 1, 0, 0, 0, 8'h09, 8'h09, 0));
    vq_b.push_back(mk(0, 0, 8'h00, 1, 0, 0, 0, 8'h08, 8'h08, 0));
    vq_b.push_back(mk(0, 1, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 0));
    vq_b.push_back(mk(0, 0, 8'h00, 1, 0, 1, 1, 8'h99, 8'h00, 0));
    vq_b.push_back(mk(0, 0, 8'h00, 1, 0, 0, 1, 8'h98, 8'h00, 0));
    vq_b.push_back(mk(1, 1, 8'h55, 1, 1, 0, 0, 8'h00, 8'h00, 0));
    vq_b.push_back(mk(0, 1, 8'h55, 1, 1, 0, 0, 8'h55, 8'h55, 0));
    vq_b.push_back(mk(0, 1, 8'h42, 0, 1, 0, 0, 8'h42, 8'h42, 0));
    vq_b.push_back(mk(0, 1, 8'h4A, 0, 1, 0, 0, 8'h42, 8'h42, 1));
    vq_b.push_back(mk(0, 0, 8'h00, 0, 1, 0, 0, 8'h42, 8'h42, 0));
    vq_b.push_back(mk(0, 1, 8'h4A, 1, 1, 0, 0, 8'h42, 8'h42, 1));
    vq_b.push_back(mk(0, 0, 8'h00, 0, 1, 0, 0, 8'h42, 8'h42, 0));
    vq_b.push_back(mk(0, 0, 8'h00, 1, 1, 0, 0, 8'h43, 8'h43, 0));
    vq_b.push_back(mk(0, 0, 8'h00, 1, 0, 0, 0, 8'h42, 8'h42, 0));
    vq_b.push_back(mk(0, 1, 8'h99, 0, 1, 0, 0, 8'h99, 8'h99, 0));
    vq_b.push_back(mk(1, 0, 8'h00, 1, 1, 0, 0, 8'h00, 8'h00, 0));
    vq_b.push_back(mk(0, 1, 8'hA0, 0, 1, 0, 0, 8'h00, 8'h00, 1));
    vq_b.push_back(mk(1, 1, 8'hAA, 0, 1, 0, 0, 8'h00, 8'h00, 0));
    vq_b.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 0));

    #1 clr = 1'b0;
    #3;
    check("reset q_wrap",   32'(q_w),   32'h00);
    check("reset q_sat",    32'(q_s),   32'h00);
    check("reset err_wrap", 32'(err_w), 32'h0);
    check("reset tc_wrap",  32'(tc_w),  32'h0);
    @(negedge clk);
    clr = 1'b1;

    foreach (vq_a[i]) drive_vec(vq_a[i], $sformatf("a%0d", i));

    // Asynchronous clear in the middle of a clock period.
    @(negedge clk);
    sync_clr = 1'b0; load = 1'b0; en = 1'b0; up_dn = 1'b1;
    #2 clr = 1'b0;
    #1;
    check("async_clr q_wrap", 32'(q_w),   32'h00);
    check("async_clr q_sat",  32'(q_s),   32'h00);
    check("async_clr err",    32'(err_w), 32'h0);
    @(negedge clk);
    clr = 1'b1; en = 1'b1; up_dn = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("count_up%0d q_wrap", k), 32'(q_w), 32'(to_bcd(k)));
      check($sformatf("count_up%0d q_sat", k),  32'(q_s), 32'(to_bcd(k)));
    end

    foreach (vq_b[i]) drive_vec(vq_b[i], $sformatf("b%0d", i));

    // Cascade of two single-digit counters; the main pair is idle here.
    @(negedge clk);
    sync_clr = 1'b0; load = 1'b0; en = 1'b0;
    cen = 1'b1;
    for (int k = 0; k < 100; k++) begin
      #1;
      check($sformatf("cascade%0d lo_tc", k), 32'(lo_tc), 32'((k % 10) == 9));
      check($sformatf("cascade%0d hi_tc", k), 32'(hi_tc), 32'(k == 99));
      @(posedge clk);
      #1;
      check($sformatf("cascade%0d value", k), 32'({hi_q, lo_q}), 32'(to_bcd((k + 1) % 100)));
      @(negedge clk);
    end
    cen = 1'b0;
    check("cascade lo_err", 32'(lo_err), 32'h0);
    check("cascade hi_err", 32'(hi_err), 32'h0);
    check("scoreboard drained", 32'(sb.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
